// File: rtl/port_alloc_sched_if.sv
// Handshake and data bundle between the route-compute stage and the
// oldest-first port allocation scheduler.
interface port_alloc_sched_if #(
    parameter int NUM_PORT = 5,
    parameter int NUM_FLIT = 4,
    parameter int AGE_W    = 8
);
    logic                         start;
    logic [NUM_FLIT-1:0]          flit_valid;
    logic [NUM_FLIT*NUM_PORT-1:0] flit_req;
    logic [NUM_FLIT*AGE_W-1:0]    flit_age;
    logic [NUM_PORT-1:0]          port_avail;
    logic                         busy;
    logic                         done;
    logic [NUM_FLIT*NUM_PORT-1:0] flit_alloc;
    logic [NUM_FLIT-1:0]          flit_deflected;
    logic [NUM_PORT-1:0]          port_remain;

    modport master (
        output start, flit_valid, flit_req, flit_age, port_avail,
        input  busy, done, flit_alloc, flit_deflected, port_remain
    );

    modport slave (
        input  start, flit_valid, flit_req, flit_age, port_avail,
        output busy, done, flit_alloc, flit_deflected, port_remain
    );
endinterface

// File: rtl/port_alloc_sched.sv
// Sequential oldest-first port allocator: one flit granted per cycle, with
// deflection onto a free network port when no requested port remains.
module port_alloc_sched #(
    parameter int NUM_PORT = 5,
    parameter int NUM_FLIT = 4,
    parameter int AGE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    port_alloc_sched_if.slave  bus
);
    localparam int IDX_W = (NUM_FLIT > 1) ? $clog2(NUM_FLIT) : 1;
    // The local/eject port (MSB) is never a deflection target.
    localparam logic [NUM_PORT-1:0] NET_MASK = {1'b0, {(NUM_PORT-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ALLOC, DONE} state_t;

    state_t                             state_reg, state_next;
    logic [NUM_FLIT-1:0]                pending_reg;
    logic [NUM_FLIT-1:0][NUM_PORT-1:0]  req_reg;
    logic [NUM_FLIT-1:0][AGE_W-1:0]     age_reg;
    logic [NUM_PORT-1:0]                avail_reg;
    logic [NUM_PORT-1:0]                remain_reg;
    logic [NUM_FLIT-1:0][NUM_PORT-1:0]  alloc_vec;
    logic [NUM_FLIT-1:0]                defl_vec;

    logic                accept;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [AGE_W-1:0]    best_age;
    logic [NUM_FLIT-1:0] sel_oh;
    logic [NUM_PORT-1:0] sel_req, prod_cand, grant;
    logic                deflect;
    logic [NUM_FLIT-1:0] pending_next;
    logic [NUM_PORT-1:0] avail_next;

    function automatic logic [NUM_PORT-1:0] hi_bit(input logic [NUM_PORT-1:0] v);
        logic [NUM_PORT-1:0] r;
        r = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (v[p]) begin
                r    = '0;
                r[p] = 1'b1;
            end
        end
        return r;
    endfunction

    assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);

    // Strict '>' keeps the lowest index on an age tie.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < NUM_FLIT; i++) begin
            if (pending_reg[i] && (!sel_found || age_reg[i] > best_age)) begin
                sel_found = 1'b1;
                best_age  = age_reg[i];
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_oh    = sel_found ? (NUM_FLIT'(1) << sel_idx) : '0;
        sel_req   = req_reg[sel_idx];
        prod_cand = sel_req & avail_reg;
        grant     = '0;
        deflect   = 1'b0;
        if (sel_found) begin
            if (prod_cand != '0) begin
                grant = hi_bit(prod_cand);
            end else if (sel_req != '0) begin
                grant   = hi_bit(avail_reg & NET_MASK);
                deflect = 1'b1;
            end
        end
        pending_next = pending_reg & ~sel_oh;
        avail_next   = avail_reg & ~grant;
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = ALLOC;
            ALLOC:   if (pending_next == '0) state_next = DONE;
            DONE:    state_next = bus.start ? ALLOC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg == ALLOC);
        bus.done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= '0;
            req_reg     <= '0;
            age_reg     <= '0;
            avail_reg   <= '0;
            remain_reg  <= '0;
        end else if (accept) begin
            pending_reg <= bus.flit_valid;
            req_reg     <= bus.flit_req;
            age_reg     <= bus.flit_age;
            avail_reg   <= bus.port_avail;
        end else if (state_reg == ALLOC) begin
            pending_reg <= pending_next;
            avail_reg   <= avail_next;
            if (pending_next == '0) remain_reg <= avail_next;
        end
    end

    // Each flit owns its grant/deflect result registers.
    generate
        for (genvar gi = 0; gi < NUM_FLIT; gi++) begin : g_flit
            logic [NUM_PORT-1:0] alloc_reg;
            logic                defl_reg;

            always_ff @(posedge clk) begin
                if (reset || accept) begin
                    alloc_reg <= '0;
                    defl_reg  <= 1'b0;
                end else if (state_reg == ALLOC && sel_oh[gi]) begin
                    alloc_reg <= grant;
                    defl_reg  <= deflect;
                end
            end

            assign alloc_vec[gi] = alloc_reg;
            assign defl_vec[gi]  = defl_reg;
        end
    endgenerate

    assign bus.flit_alloc     = alloc_vec;
    assign bus.flit_deflected = defl_vec;
    assign bus.port_remain    = remain_reg;
endmodule

// File: tb/tb_port_alloc_sched.sv
// Directed scoreboard bench for port_alloc_sched: expected batch results are
// queued at start and compared when done pulses.
module tb_port_alloc_sched;
    localparam int NP = 5;
    localparam int NF = 4;
    localparam int AW = 8;

    typedef struct {
        string            tag;
        logic [NF*NP-1:0] alloc;
        logic [NF-1:0]    defl;
        logic [NP-1:0]    remain;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    port_alloc_sched_if #(.NUM_PORT(NP), .NUM_FLIT(NF), .AGE_W(AW)) bus ();

    port_alloc_sched #(.NUM_PORT(NP), .NUM_FLIT(NF), .AGE_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [NF-1:0] v, input logic [NF*NP-1:0] req,
                         input logic [NF*AW-1:0] age, input logic [NP-1:0] avail);
        bus.flit_valid = v;
        bus.flit_req   = req;
        bus.flit_age   = age;
        bus.port_avail = avail;
        bus.start      = 1'b1;
    endtask

    task automatic expect_batch(input string tag, input logic [NF*NP-1:0] alloc,
                                input logic [NF-1:0] defl, input logic [NP-1:0] remain,
                                input int lat);
        exp_t e;
        e.tag = tag; e.alloc = alloc; e.defl = defl; e.remain = remain; e.lat = lat;
        sb.push_back(e);
    endtask

    // Latch edge, then wait (bounded) for done; poke>0 raises start in that ALLOC cycle.
    task automatic wait_done(input int poke);
        exp_t e;
        int   cnt;
        bit   got;
        string tag;
        tag = sb[0].tag;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"},  32'(bus.busy), 32'd1);
        check({tag, "_clear"}, 32'({bus.flit_alloc, bus.flit_deflected}), 32'd0);
        cnt = 1;
        got = 1'b0;
        while (!got && cnt < 40) begin
            if (cnt == poke) begin
                bus.start      = 1'b1;
                bus.flit_valid = '0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        e = sb.pop_front();
        check({tag, "_lat"},    32'(cnt),                 32'(e.lat));
        check({tag, "_nobusy"}, 32'(bus.busy),            32'd0);
        check({tag, "_alloc"},  32'(bus.flit_alloc),      32'(e.alloc));
        check({tag, "_defl"},   32'(bus.flit_deflected),  32'(e.defl));
        check({tag, "_remain"}, 32'(bus.port_remain),     32'(e.remain));
        $display("batch %s: cycles=%0d alloc=%h defl=%b remain=%b",
                 tag, cnt, bus.flit_alloc, bus.flit_deflected, bus.port_remain);
    endtask

    initial begin
        int extra_done;
        bus.start      = 1'b0;
        bus.flit_valid = '0;
        bus.flit_req   = '0;
        bus.flit_age   = '0;
        bus.port_avail = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(bus.busy),           32'd0);
        check("rst_done",   32'(bus.done),           32'd0);
        check("rst_alloc",  32'(bus.flit_alloc),     32'd0);
        check("rst_defl",   32'(bus.flit_deflected), 32'd0);
        check("rst_remain", 32'(bus.port_remain),    32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single productive flit
        drive(4'b0001, {5'b0, 5'b0, 5'b0, 5'b00010}, {8'd0, 8'd0, 8'd0, 8'd3}, 5'b11111);
        expect_batch("single", {5'b0, 5'b0, 5'b0, 5'b00010}, 4'b0000, 5'b11101, 2);
        wait_done(0);

        // Older flit wins the contended port, the younger one deflects
        drive(4'b0011, {5'b0, 5'b0, 5'b00100, 5'b00100}, {8'd0, 8'd0, 8'd9, 8'd5}, 5'b11111);
        expect_batch("age", {5'b0, 5'b0, 5'b00100, 5'b01000}, 4'b0001, 5'b10011, 3);
        wait_done(0);

        // Age tie to lower index; deflection never lands on the local port
        drive(4'b1100, {5'b10000, 5'b10000, 5'b0, 5'b0}, {8'd7, 8'd7, 8'd0, 8'd0}, 5'b10001);
        expect_batch("tie", {5'b00001, 5'b10000, 5'b0, 5'b0}, 4'b1000, 5'b00000, 3);
        wait_done(0);

        // Empty batch
        drive(4'b0000, {5'b11111, 5'b11111, 5'b11111, 5'b11111}, '0, 5'b10110);
        expect_batch("empty", '0, 4'b0000, 5'b10110, 2);
        wait_done(0);

        // Full batch with an ignored start during ALLOC; done fires once
        drive(4'b1111, {5'b01000, 5'b00100, 5'b00010, 5'b00001}, {8'd4, 8'd3, 8'd2, 8'd1}, 5'b11111);
        expect_batch("full", {5'b01000, 5'b00100, 5'b00010, 5'b00001}, 4'b0000, 5'b10000, 5);
        wait_done(2);
        extra_done = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.done) extra_done++;
        end
        check("full_once", 32'(extra_done), 32'd0);

        // Invalid flit ignored, zero-request flit gets no grant, tie by index
        drive(4'b1011, {5'b00011, 5'b11111, 5'b00000, 5'b10000},
              {8'd200, 8'd255, 8'd255, 8'd200}, 5'b10010);
        expect_batch("mixed", {5'b00010, 5'b0, 5'b0, 5'b10000}, 4'b0000, 5'b00000, 4);
        wait_done(0);

        // Reset in the second ALLOC cycle
        drive(4'b1111, {5'b01000, 5'b00100, 5'b00010, 5'b00001}, {8'd4, 8'd3, 8'd2, 8'd1}, 5'b11111);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy",   32'(bus.busy),           32'd0);
        check("mid_rst_done",   32'(bus.done),           32'd0);
        check("mid_rst_alloc",  32'(bus.flit_alloc),     32'd0);
        check("mid_rst_defl",   32'(bus.flit_deflected), 32'd0);
        check("mid_rst_remain", 32'(bus.port_remain),    32'd0);
        drive(4'b0001, {5'b0, 5'b0, 5'b0, 5'b00010}, {8'd0, 8'd0, 8'd0, 8'd3}, 5'b11111);
        expect_batch("post_rst", {5'b0, 5'b0, 5'b0, 5'b00010}, 4'b0000, 5'b11101, 2);
        wait_done(0);

        // Back-to-back: second start issued in the DONE cycle of the first
        drive(4'b0011, {5'b0, 5'b0, 5'b00100, 5'b00100}, {8'd0, 8'd0, 8'd9, 8'd5}, 5'b11111);
        expect_batch("b2b_a", {5'b0, 5'b0, 5'b00100, 5'b01000}, 4'b0001, 5'b10011, 3);
        wait_done(0);
        drive(4'b1100, {5'b10000, 5'b10000, 5'b0, 5'b0}, {8'd7, 8'd7, 8'd0, 8'd0}, 5'b10001);
        expect_batch("b2b_b", {5'b00001, 5'b10000, 5'b0, 5'b0}, 4'b1000, 5'b00000, 3);
        wait_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
